// File: rtl/mem_bus_arbiter_if.sv
// Bundle of cache-side and memory-side signals around the memory bus arbiter.
// The arbiter takes the slave view; whoever drives the caches/bridge takes master.
`ifndef REQ_READ
`define REQ_READ 1'b0
`endif
`ifndef REQ_WRITE
`define REQ_WRITE 1'b1
`endif

interface mem_bus_arbiter_if #(
    parameter int ADR_WIDTH  = 32,
    parameter int DATA_WIDTH = 128
);
    logic                  i_ich_valid;
    logic [ADR_WIDTH-1:0]  i_ich_addr;
    logic [1:0]            i_ich_size;
    logic                  o_ich_ready;
    logic [DATA_WIDTH-1:0] o_ich_rdata;

    logic                  i_dch_valid;
    logic                  i_dch_reqtyp;
    logic [ADR_WIDTH-1:0]  i_dch_addr;
    logic [DATA_WIDTH-1:0] i_dch_wdata;
    logic [1:0]            i_dch_size;
    logic                  o_dch_ready;
    logic [DATA_WIDTH-1:0] o_dch_rdata;

    logic                  o_mem_valid;
    logic                  o_mem_reqtyp;
    logic [ADR_WIDTH-1:0]  o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic [1:0]            o_mem_size;
    logic                  i_mem_ready;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    logic [1:0]            o_owner;

    modport slave (
        input  i_ich_valid, i_ich_addr, i_ich_size,
        output o_ich_ready, o_ich_rdata,
        input  i_dch_valid, i_dch_reqtyp, i_dch_addr,
        input  i_dch_wdata, i_dch_size,
        output o_dch_ready, o_dch_rdata,
        output o_mem_valid, o_mem_reqtyp, o_mem_addr,
        output o_mem_wdata, o_mem_size,
        input  i_mem_ready, i_mem_rdata,
        output o_owner
    );

    modport master (
        output i_ich_valid, i_ich_addr, i_ich_size,
        input  o_ich_ready, o_ich_rdata,
        output i_dch_valid, i_dch_reqtyp, i_dch_addr,
        output i_dch_wdata, i_dch_size,
        input  o_dch_ready, o_dch_rdata,
        input  o_mem_valid, o_mem_reqtyp, o_mem_addr,
        input  o_mem_wdata, o_mem_size,
        output i_mem_ready, i_mem_rdata,
        input  o_owner
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the 128-bit memory port between iCache refill and dCache traffic.
// One grant at a time, held until the owner's transaction completes.
`ifndef REQ_READ
`define REQ_READ 1'b0
`endif
`ifndef REQ_WRITE
`define REQ_WRITE 1'b1
`endif

module mem_bus_arbiter #(
    parameter int ADR_WIDTH  = 32,
    parameter int DATA_WIDTH = 128,
    parameter int FIXED_PRIO = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mem_bus_arbiter_if.slave bus
);
    // Encoding doubles as the o_owner value.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   last_d_q, last_d_d;
    logic   pick_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        last_d_d         = last_d_q;
        pick_d           = 1'b0;
        bus.o_mem_valid  = 1'b0;
        bus.o_mem_reqtyp = `REQ_READ;
        bus.o_mem_addr   = {ADR_WIDTH{1'b0}};
        bus.o_mem_wdata  = {DATA_WIDTH{1'b0}};
        bus.o_mem_size   = 2'b00;
        bus.o_ich_ready  = 1'b0;
        bus.o_ich_rdata  = {DATA_WIDTH{1'b0}};
        bus.o_dch_ready  = 1'b0;
        bus.o_dch_rdata  = {DATA_WIDTH{1'b0}};
        bus.o_owner      = state_q;

        unique case (state_q)
            IDLE: begin
                // dCache wins a conflict unless it won the previous one.
                pick_d = bus.i_dch_valid
                       & (~bus.i_ich_valid
                          | (FIXED_PRIO != 0)
                          | ~last_d_q);
                if (pick_d) begin
                    state_d  = GNT_D;
                    last_d_d = 1'b1;
                end else if (bus.i_ich_valid) begin
                    state_d  = GNT_I;
                    last_d_d = 1'b0;
                end
            end
            GNT_I: begin
                bus.o_mem_valid = bus.i_ich_valid;
                bus.o_mem_addr  = bus.i_ich_addr;
                bus.o_mem_size  = bus.i_ich_size;
                bus.o_ich_ready = bus.i_ich_valid & bus.i_mem_ready;
                bus.o_ich_rdata = bus.i_mem_rdata;
                if (~bus.i_ich_valid | bus.i_mem_ready) begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                bus.o_mem_valid  = bus.i_dch_valid;
                bus.o_mem_reqtyp = bus.i_dch_reqtyp;
                bus.o_mem_addr   = bus.i_dch_addr;
                bus.o_mem_wdata  = bus.i_dch_wdata;
                bus.o_mem_size   = bus.i_dch_size;
                bus.o_dch_ready  = bus.i_dch_valid & bus.i_mem_ready;
                bus.o_dch_rdata  = bus.i_mem_rdata;
                if (~bus.i_dch_valid | bus.i_mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one round-robin and one fixed-priority
// instance, each shadowed every cycle by a transaction-level owner model.
`ifndef REQ_READ
`define REQ_READ 1'b0
`endif
`ifndef REQ_WRITE
`define REQ_WRITE 1'b1
`endif

module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    logic         ich_valid [2];
    logic [31:0]  ich_addr  [2];
    logic [1:0]   ich_size  [2];
    logic         dch_valid [2];
    logic         dch_typ   [2];
    logic [31:0]  dch_addr  [2];
    logic [127:0] dch_wdata [2];
    logic [1:0]   dch_size  [2];
    logic         mem_ready [2];
    logic [127:0] mem_rdata [2];

    logic         ir_o  [2];
    logic [127:0] ird_o [2];
    logic         dr_o  [2];
    logic [127:0] drd_o [2];
    logic         mv_o  [2];
    logic         typ_o [2];
    logic [31:0]  addr_o[2];
    logic [127:0] wd_o  [2];
    logic [1:0]   sz_o  [2];
    logic [1:0]   own_o [2];

    task automatic check(input string nm,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        mem_bus_arbiter_if #(.ADR_WIDTH(32), .DATA_WIDTH(128)) bus ();

        mem_bus_arbiter #(
            .ADR_WIDTH(32), .DATA_WIDTH(128), .FIXED_PRIO(g)
        ) dut (
            .i_clk(clk),
            .i_rst(rst),
            .bus  (bus)
        );

        assign bus.i_ich_valid  = ich_valid[g];
        assign bus.i_ich_addr   = ich_addr[g];
        assign bus.i_ich_size   = ich_size[g];
        assign bus.i_dch_valid  = dch_valid[g];
        assign bus.i_dch_reqtyp = dch_typ[g];
        assign bus.i_dch_addr   = dch_addr[g];
        assign bus.i_dch_wdata  = dch_wdata[g];
        assign bus.i_dch_size   = dch_size[g];
        assign bus.i_mem_ready  = mem_ready[g];
        assign bus.i_mem_rdata  = mem_rdata[g];
        assign ir_o[g]   = bus.o_ich_ready;
        assign ird_o[g]  = bus.o_ich_rdata;
        assign dr_o[g]   = bus.o_dch_ready;
        assign drd_o[g]  = bus.o_dch_rdata;
        assign mv_o[g]   = bus.o_mem_valid;
        assign typ_o[g]  = bus.o_mem_reqtyp;
        assign addr_o[g] = bus.o_mem_addr;
        assign wd_o[g]   = bus.o_mem_wdata;
        assign sz_o[g]   = bus.o_mem_size;
        assign own_o[g]  = bus.o_owner;

        // Model: who owns the bus (0 none, 1 iCache, 2 dCache) and who won last.
        int owner = 0;
        int last  = 1;
        int win;
        logic         e_mv, e_typ, e_ir, e_dr;
        logic [1:0]   e_sz;
        logic [31:0]  e_addr;
        logic [127:0] e_wd, e_ird, e_drd;

        always @(negedge clk) begin
            e_mv   = (owner == 1) ? ich_valid[g] :
                     (owner == 2) ? dch_valid[g] : 1'b0;
            e_typ  = (owner == 2) ? dch_typ[g] : `REQ_READ;
            e_addr = (owner == 1) ? ich_addr[g] :
                     (owner == 2) ? dch_addr[g] : 32'h0;
            e_sz   = (owner == 1) ? ich_size[g] :
                     (owner == 2) ? dch_size[g] : 2'b00;
            e_wd   = (owner == 2) ? dch_wdata[g] : 128'h0;
            e_ir   = (owner == 1) && e_mv && mem_ready[g];
            e_dr   = (owner == 2) && e_mv && mem_ready[g];
            e_ird  = (owner == 1) ? mem_rdata[g] : 128'h0;
            e_drd  = (owner == 2) ? mem_rdata[g] : 128'h0;
            if (chk_on) begin
                check($sformatf("owner%0d", g), own_o[g], owner[1:0]);
                check($sformatf("memreq%0d", g),
                      {mv_o[g], typ_o[g], sz_o[g]}, {e_mv, e_typ, e_sz});
                check($sformatf("addr%0d", g), addr_o[g], e_addr);
                check($sformatf("wdata%0d", g), wd_o[g], e_wd);
                check($sformatf("ich%0d", g), {ir_o[g], ird_o[g]},
                      {e_ir, e_ird});
                check($sformatf("dch%0d", g), {dr_o[g], drd_o[g]},
                      {e_dr, e_drd});
            end
            if (rst) begin
                owner = 0;
                last  = 1;
            end else if (owner == 0) begin
                win = 0;
                if (ich_valid[g] && dch_valid[g])
                    win = (g == 1 || last == 1) ? 2 : 1;
                else if (ich_valid[g])
                    win = 1;
                else if (dch_valid[g])
                    win = 2;
                owner = win;
                if (win != 0) last = win;
            end else if (!e_mv || mem_ready[g]) begin
                owner = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear(input int d);
        ich_valid[d] = 1'b0; ich_addr[d] = '0; ich_size[d] = '0;
        dch_valid[d] = 1'b0; dch_typ[d] = `REQ_READ;
        dch_addr[d] = '0; dch_wdata[d] = '0; dch_size[d] = '0;
        mem_ready[d] = 1'b0; mem_rdata[d] = '0;
    endtask

    logic [1:0] glog [6];
    logic [1:0] rr_exp [6];
    int ng;

    initial begin
        rr_exp = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
        clear(0);
        clear(1);
        repeat (2) tick();
        rst = 1'b0;
        chk_on = 1'b1;
        #1;
        check("rst_owner", own_o[0], 2'b00);
        check("rst_outs", {mv_o[0], ir_o[0], dr_o[0], addr_o[0]}, 35'h0);

        // single iCache refill
        ich_valid[0] = 1'b1;
        ich_addr[0]  = 32'h8000_0010;
        ich_size[0]  = 2'b11;
        #1;
        check("idle_no_comb", mv_o[0], 1'b0);
        tick();
        check("i_grant", {own_o[0], mv_o[0], sz_o[0]}, {2'b01, 1'b1, 2'b11});
        check("i_addr", addr_o[0], 32'h8000_0010);
        tick();
        tick();
        mem_ready[0] = 1'b1;
        mem_rdata[0] = 128'h0123_4567_89ab_cdef_0011_2233_4455_66a5;
        #1;
        check("i_ready", {ir_o[0], dr_o[0]}, 2'b10);
        check("i_rdata", ird_o[0], 128'h0123_4567_89ab_cdef_0011_2233_4455_66a5);
        tick();
        ich_valid[0] = 1'b0;
        mem_ready[0] = 1'b0;
        #1;
        check("i_done", {own_o[0], ir_o[0]}, 3'b000);

        // simultaneous requests: dCache first, bubble, then iCache
        ich_valid[0] = 1'b1; ich_addr[0] = 32'h8000_0020;
        dch_valid[0] = 1'b1; dch_addr[0] = 32'h8000_0040;
        dch_size[0]  = 2'b11;
        tick();
        check("both_d_first", own_o[0], 2'b10);
        check("both_d_addr", addr_o[0], 32'h8000_0040);
        mem_ready[0] = 1'b1;
        mem_rdata[0] = 128'h5a5a;
        #1;
        check("both_d_ready", {dr_o[0], ir_o[0], ird_o[0]}, {2'b10, 128'h0});
        tick();
        dch_valid[0] = 1'b0;
        mem_ready[0] = 1'b0;
        #1;
        check("bubble", {own_o[0], mv_o[0]}, 3'b000);
        tick();
        check("both_i_next", own_o[0], 2'b01);
        mem_ready[0] = 1'b1;
        #1;
        check("both_i_ready", ir_o[0], 1'b1);
        tick();
        clear(0);

        // continuous contention alternates
        ich_valid[0] = 1'b1; ich_addr[0] = 32'h8000_0030;
        dch_valid[0] = 1'b1; dch_addr[0] = 32'h8000_0050;
        ng = 0;
        for (int k = 0; k < 40 && ng < 6; k++) begin
            tick();
            if (own_o[0] != 2'b00) begin
                glog[ng] = own_o[0];
                ng++;
                mem_ready[0] = 1'b1;
                mem_rdata[0] = 128'(k);
            end else begin
                mem_ready[0] = 1'b0;
            end
        end
        check("rr_count", 128'(ng), 128'd6);
        for (int i = 0; i < ng; i++) check($sformatf("rr_order%0d", i), glog[i], rr_exp[i]);
        tick();
        clear(0);

        // dCache writeback forwarded untouched
        dch_valid[0] = 1'b1;
        dch_typ[0]   = `REQ_WRITE;
        dch_addr[0]  = 32'h8000_0100;
        dch_wdata[0] = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        dch_size[0]  = 2'b11;
        tick();
        check("wr_req", {mv_o[0], typ_o[0], sz_o[0]}, 4'b1111);
        check("wr_addr", addr_o[0], 32'h8000_0100);
        check("wr_data", wd_o[0], 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
        mem_ready[0] = 1'b1;
        #1;
        check("wr_ready", {dr_o[0], ir_o[0]}, 2'b10);
        tick();
        clear(0);

        // reset in the middle of an iCache grant, then a stray ready
        ich_valid[0] = 1'b1; ich_addr[0] = 32'h8000_0200; ich_size[0] = 2'b11;
        tick();
        check("rst_mid_grant", own_o[0], 2'b01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ich_valid[0] = 1'b0;
        mem_ready[0] = 1'b1;
        mem_rdata[0] = 128'hffff;
        #1;
        check("rst_mid_outs",
              {own_o[0], mv_o[0], ir_o[0], dr_o[0], addr_o[0]}, 37'h0);
        check("stray_rdata", {ird_o[0], drd_o[0]}, 256'h0);
        tick();
        mem_ready[0] = 1'b0;
        #1;
        check("stray_idle", {own_o[0], ir_o[0]}, 3'b000);

        // fixed priority instance: dCache wins until it lets go
        ich_valid[1] = 1'b1; ich_addr[1] = 32'h8000_0300; ich_size[1] = 2'b11;
        dch_valid[1] = 1'b1; dch_addr[1] = 32'h8000_0400; dch_size[1] = 2'b11;
        ng = 0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            tick();
            if (own_o[1] != 2'b00) begin
                glog[ng] = own_o[1];
                ng++;
                mem_ready[1] = 1'b1;
            end else begin
                mem_ready[1] = 1'b0;
            end
        end
        check("fp_count", 128'(ng), 128'd4);
        for (int i = 0; i < ng; i++) check($sformatf("fp_order%0d", i), glog[i], 2'b10);
        tick();
        dch_valid[1] = 1'b0;
        mem_ready[1] = 1'b0;
        #1;
        check("fp_bubble", own_o[1], 2'b00);
        tick();
        check("fp_i_after", own_o[1], 2'b01);
        mem_ready[1] = 1'b1;
        #1;
        check("fp_i_ready", ir_o[1], 1'b1);
        tick();
        clear(1);
        tick();
        tick();

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 128-bit memory-side port between iCache refill and dCache refill/writeback requests.
- Sits between the cache masters (iMemIf_M / dMemIf_M) and the memory bridge.
- Grants one requester at a time and holds the grant until its transaction completes.
- Round-robin fairness by default; fixed dCache priority optional.

Parameters:
- ADR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 128, cacheline transfer width.
- FIXED_PRIO, 0, 0 = round-robin on conflict; 1 = dCache always wins conflicts.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_ich_valid  in  1  iCache request valid, held until o_ich_ready
- i_ich_addr  in  ADR_WIDTH  iCache request address (16B aligned)
- i_ich_size  in  2  iCache request size (always 2'b11)
- o_ich_ready  out  1  iCache completion pulse
- o_ich_rdata  out  DATA_WIDTH  iCache read data, valid with o_ich_ready
- i_dch_valid  in  1  dCache request valid, held until o_dch_ready
- i_dch_reqtyp  in  1  `REQ_READ / `REQ_WRITE
- i_dch_addr  in  ADR_WIDTH  dCache request address
- i_dch_wdata  in  DATA_WIDTH  dCache write data
- i_dch_size  in  2  dCache request size
- o_dch_ready  out  1  dCache completion pulse
- o_dch_rdata  out  DATA_WIDTH  dCache read data, valid with o_dch_ready
- o_mem_valid  out  1  downstream request valid
- o_mem_reqtyp  out  1  downstream request type
- o_mem_addr  out  ADR_WIDTH  downstream address
- o_mem_wdata  out  DATA_WIDTH  downstream write data
- o_mem_size  out  2  downstream size
- i_mem_ready  in  1  downstream completion pulse
- i_mem_rdata  in  DATA_WIDTH  downstream read data, valid with i_mem_ready
- o_owner  out  2  2'b00 none, 2'b01 iCache, 2'b10 dCache

Behaviour:
- Reset (i_rst high at a clock edge):
  - state = IDLE; last_grant = iCache, so dCache wins the first conflict.
  - All outputs are 0, including the data/address muxes, o_owner = 0 and both ready outputs.
  - Reset mid-transaction abandons the grant; a late i_mem_ready arriving while in IDLE is ignored (no upstream ready).
- States: IDLE, GNT_I, GNT_D. The state is registered.
- IDLE:
  - Only i_ich_valid -> GNT_I. Only i_dch_valid -> GNT_D. Neither -> stay.
  - Both valid, FIXED_PRIO=0: grant the requester not equal to last_grant. FIXED_PRIO=1: GNT_D.
  - On any grant, last_grant is updated to the winner.
  - o_mem_valid = 0 in IDLE. The grant decision costs exactly one cycle: valid at cycle N gives o_mem_valid at N+1.
- GNT_I:
  - o_mem_valid = i_ich_valid; o_mem_reqtyp = `REQ_READ; o_mem_addr = i_ich_addr; o_mem_wdata = 0; o_mem_size = i_ich_size.
  - o_ich_ready = i_mem_ready & o_mem_valid; o_ich_rdata = i_mem_rdata when owner, else 0.
- GNT_D: mirror of GNT_I using the dCache fields, including reqtyp and wdata.
- Exit from a grant:
  - o_mem_valid & i_mem_ready -> IDLE next cycle. There is one bubble cycle between back-to-back transactions.
  - Owner drops valid before ready (protocol violation) -> IDLE next cycle; nothing is forwarded.
- The non-owner's ready and rdata are always 0. A non-owner request stays pending and needs no buffering, since the requester holds valid.
- o_owner reflects state combinationally: IDLE = 00, GNT_I = 01, GNT_D = 10.
- Starvation bound (FIXED_PRIO=0): with both requesters continuously valid, grants alternate I/D/I/D…
- No combinational path from i_*_valid to o_mem_valid while in IDLE.
- i_mem_ready may arrive in the same cycle that o_mem_valid first rises; that is a one-cycle transaction and is legal.

Test Plan:
- Reset then i_ich_valid=1, addr=0x8000_0010 -> o_mem_valid=1 at next cycle with o_mem_addr=0x8000_0010 and size=2'b11. i_mem_ready with rdata=0x…A5 three cycles later -> o_ich_ready pulses 1 cycle with rdata=0x…A5. o_owner goes 01 then 00.
- Both valid at the same cycle after reset (FIXED_PRIO=0): dCache granted first. After its ready -> one IDLE bubble -> iCache granted. o_ich_ready never pulses during the dCache grant.
- Both held valid continuously for 6 transactions -> grant order D,I,D,I,D,I.
- FIXED_PRIO=1, same stimulus -> dCache granted every time; iCache is granted only once dCache drops valid.
- dCache write: reqtyp=`REQ_WRITE, wdata=0xDEAD…BEEF, addr=0x8000_0100 -> forwarded unchanged; o_dch_ready is 1 on the i_mem_ready cycle.
- Assert i_rst mid GNT_I before ready -> all outputs 0 on the next cycle and o_owner=00. A subsequent stray i_mem_ready produces no upstream ready pulse.
